// File: rtl/fpga_election_pkg.sv
// Shared defaults, block-count helper and read-FSM state type for the
// decryptor-side SPI frame path.
package fpga_election_pkg;

  localparam int DEF_REGISTER_SIZE = 32;
  localparam int DEF_BITS_IN_NUM   = 4096;

  function automatic int num_blocks(input int bits_in_num, input int register_size);
    return bits_in_num / register_size;
  endfunction

  typedef enum logic [1:0] {
    R_IDLE,
    R_LOAD,
    R_PRESENT
  } rd_state_e;

endpackage

// File: rtl/evt_counter.sv
// Free-running event counter; increments once per cycle that inc_in is high,
// wrapping at 2^WIDTH.
module evt_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             inc_in,
  output logic [WIDTH-1:0] count_out
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_in) begin
    if (rst_in)      count_q <= '0;
    else if (inc_in) count_q <= count_q + 1'b1;
  end

  assign count_out = count_q;

endmodule

// File: rtl/frame_bank_ram.sv
// Simple dual-port RAM with one-cycle registered read, shaped for block-RAM
// inference: one write port, one read port, no reset on the array.
module frame_bank_ram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk_in,
  input  logic              we_in,
  input  logic [ADDR_W-1:0] waddr_in,
  input  logic [WIDTH-1:0]  wdata_in,
  input  logic              re_in,
  input  logic [ADDR_W-1:0] raddr_in,
  output logic [WIDTH-1:0]  rdata_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the array and read register are deliberately not reset; a reset
  // would stop block-RAM inference, and contents are never read before written.
  always_ff @(posedge clk_in) begin
    if (we_in) mem_q[waddr_in] <= wdata_in;
    if (re_in) rdata_q <= mem_q[raddr_in];
  end

  assign rdata_out = rdata_q;

endmodule

// File: rtl/spi_frame_collector.sv
// Assembles SPI blocks (LS block first) into full frames in a two-bank
// ping-pong buffer and re-streams complete frames over valid/consumed.
module spi_frame_collector
  import fpga_election_pkg::*;
#(
  parameter int REGISTER_SIZE  = DEF_REGISTER_SIZE,
  parameter int BITS_IN_NUM    = DEF_BITS_IN_NUM,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] data_in,
  input  logic                     valid_in,
  input  logic                     consumed_in,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     valid_out,
  output logic                     last_out,
  output logic                     dropped_out,
  output logic                     timeout_out,
  output logic [15:0]              frames_out
);

  localparam int NB    = num_blocks(BITS_IN_NUM, REGISTER_SIZE);
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NB - 1);
  localparam logic [TW-1:0]    TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]       full_q, full_d;
  logic             wbank_q, wbank_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             dropped_q, dropped_d;
  logic             timeout_q, timeout_d;
  logic             wr_en, frame_done;

  rd_state_e        state_q, state_d;
  logic             rbank_q, rbank_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic             rd_en, rd_done;
  logic [REGISTER_SIZE-1:0] rd_data;

  // NOTE: every always_comb output gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    wbank_d    = wbank_q;
    widx_d     = widx_q;
    tcnt_d     = tcnt_q;
    dropped_d  = 1'b0;
    timeout_d  = 1'b0;
    frame_done = 1'b0;
    wr_en      = valid_in && !full_q[wbank_q];
    if (valid_in && full_q[wbank_q]) dropped_d = 1'b1;
    if (wr_en) begin
      tcnt_d = '0;
      if (widx_q == LAST_IDX) begin
        widx_d     = '0;
        wbank_d    = ~wbank_q;
        frame_done = 1'b1;
      end else begin
        widx_d = widx_q + 1'b1;
      end
    end else if (widx_q != '0) begin
      if (tcnt_q == TOUT_LAST) begin
        widx_d    = '0;
        tcnt_d    = '0;
        timeout_d = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end else begin
      tcnt_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    rbank_d = rbank_q;
    ridx_d  = ridx_q;
    rd_en   = 1'b0;
    rd_done = 1'b0;
    case (state_q)
      R_IDLE:    if (full_q[rbank_q]) state_d = R_LOAD;
      R_LOAD: begin
        rd_en   = 1'b1;
        state_d = R_PRESENT;
      end
      R_PRESENT: if (consumed_in) begin
        if (ridx_q == LAST_IDX) begin
          rd_done = 1'b1;
          rbank_d = ~rbank_q;
          ridx_d  = '0;
          state_d = R_IDLE;
        end else begin
          ridx_d  = ridx_q + 1'b1;
          state_d = R_LOAD;
        end
      end
      default:   state_d = R_IDLE;
    endcase
  end

  // The writer only completes into a non-full bank and the reader only
  // frees a full one, so the two updates never target the same bank.
  always_comb begin
    full_d = full_q;
    if (frame_done) full_d[wbank_q] = 1'b1;
    if (rd_done)    full_d[rbank_q] = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      full_q    <= '0;
      wbank_q   <= 1'b0;
      widx_q    <= '0;
      tcnt_q    <= '0;
      dropped_q <= 1'b0;
      timeout_q <= 1'b0;
      state_q   <= R_IDLE;
      rbank_q   <= 1'b0;
      ridx_q    <= '0;
    end else begin
      full_q    <= full_d;
      wbank_q   <= wbank_d;
      widx_q    <= widx_d;
      tcnt_q    <= tcnt_d;
      dropped_q <= dropped_d;
      timeout_q <= timeout_d;
      state_q   <= state_d;
      rbank_q   <= rbank_d;
      ridx_q    <= ridx_d;
    end
  end

  frame_bank_ram #(
    .WIDTH  (REGISTER_SIZE),
    .ADDR_W (IDX_W + 1)
  ) u_ram (
    .clk_in    (clk_in),
    .we_in     (wr_en),
    .waddr_in  ({wbank_q, widx_q}),
    .wdata_in  (data_in),
    .re_in     (rd_en),
    .raddr_in  ({rbank_q, ridx_q}),
    .rdata_out (rd_data)
  );

  evt_counter #(.WIDTH(16)) u_frames (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .inc_in    (frame_done),
    .count_out (frames_out)
  );

  // The RAM read register is unreset, so data_out is gated to read as zero
  // whenever no block is being presented.
  assign valid_out   = (state_q == R_PRESENT);
  assign last_out    = valid_out && (ridx_q == LAST_IDX);
  assign data_out    = valid_out ? rd_data : '0;
  assign dropped_out = dropped_q;
  assign timeout_out = timeout_q;

endmodule

// File: tb/tb_spi_frame_collector.sv
// Directed self-checking bench for spi_frame_collector with 4-block frames
// and a 16-cycle inter-block timeout.
module tb_spi_frame_collector;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        consumed_in = 1'b0;
  logic [31:0] data_out;
  logic        valid_out, last_out, dropped_out, timeout_out;
  logic [15:0] frames_out;

  int passed = 0;
  int total  = 0;

  int          drop_cnt = 0;
  int          to_cnt   = 0;
  logic [32:0] out_q[$];

  spi_frame_collector #(
    .REGISTER_SIZE  (32),
    .BITS_IN_NUM    (128),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .consumed_in (consumed_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .last_out    (last_out),
    .dropped_out (dropped_out),
    .timeout_out (timeout_out),
    .frames_out  (frames_out)
  );

  always #5 clk_in = ~clk_in;

  // Mid-cycle observers: pulse counters and a log of every accepted block.
  always @(negedge clk_in) begin
    if (dropped_out) drop_cnt++;
    if (timeout_out) to_cnt++;
    if (valid_out && consumed_in) out_q.push_back({last_out, data_out});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    valid_in = 1'b1;
    data_in  = d;
    tick();
    valid_in = 1'b0;
    data_in  = '0;
  endtask

  task automatic wait_log(input int target, input int budget);
    int n = 0;
    while (out_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    tick();
    check("log_size", out_q.size(), target);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [31:0] b0,
                             input logic [31:0] b1, input logic [31:0] b2, input logic [31:0] b3);
    logic [31:0] exp[4];
    exp = '{b0, b1, b2, b3};
    if (out_q.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        check({tag, "_data"}, out_q[base+i][31:0], exp[i]);
        check({tag, "_last"}, {31'd0, out_q[base+i][32]}, {31'd0, (i == 3)});
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"},    data_out, 32'h0);
    check({tag, "_valid"},   {31'd0, valid_out}, 32'h0);
    check({tag, "_last"},    {31'd0, last_out}, 32'h0);
    check({tag, "_dropped"}, {31'd0, dropped_out}, 32'h0);
    check({tag, "_timeout"}, {31'd0, timeout_out}, 32'h0);
    check({tag, "_frames"},  {16'd0, frames_out}, 32'h0);
  endtask

  initial begin
    logic [31:0] exp1[4];
    logic [31:0] prev_data;
    logic        prev_v, prev_c;
    int          base, d0, t0;

    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
    check_idle_outputs("reset");

    // 1: 3-cycle spaced blocks, downstream always ready.
    exp1 = '{32'h11, 32'h22, 32'h33, 32'h44};
    consumed_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(exp1[i]);
      if (i < 3) begin tick(); tick(); end
    end
    check("t1_frames", {16'd0, frames_out}, 32'd1);
    check("t1_valid_T", {31'd0, valid_out}, 32'd0);
    tick();
    check("t1_valid_T1", {31'd0, valid_out}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t1_valid", {31'd0, valid_out}, 32'd1);
      check("t1_data", data_out, exp1[i]);
      check("t1_last", {31'd0, last_out}, {31'd0, (i == 3)});
      tick();
      check("t1_gap", {31'd0, valid_out}, 32'd0);
      tick();
    end

    // 2: three frames with no consumer; third frame fully dropped.
    consumed_in = 1'b0;
    d0 = drop_cnt;
    for (int i = 0; i < 4; i++) send(32'hB0 + i);
    for (int i = 0; i < 4; i++) send(32'hC0 + i);
    for (int i = 0; i < 4; i++) send(32'hD0 + i);
    tick();
    check("t2_frames", {16'd0, frames_out}, 32'd3);
    check("t2_drops", drop_cnt - d0, 32'd4);
    check("t2_hold_data", data_out, 32'hB0);
    base = out_q.size();
    consumed_in = 1'b1;
    wait_log(base + 8, 100);
    check_frame("t2_f1", base, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
    check_frame("t2_f2", base + 4, 32'hC0, 32'hC1, 32'hC2, 32'hC3);

    // 3: partial frame then 16 idle cycles -> exactly one timeout.
    t0 = to_cnt;
    send(32'h01);
    send(32'h02);
    repeat (15) tick();
    check("t3_no_early_to", {31'd0, timeout_out}, 32'd0);
    tick();
    check("t3_to_pulse", {31'd0, timeout_out}, 32'd1);
    tick();
    tick();
    check("t3_to_count", to_cnt - t0, 32'd1);
    base = out_q.size();
    for (int i = 0; i < 4; i++) send(32'hA0 + i);
    wait_log(base + 4, 50);
    check_frame("t3", base, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    check("t3_frames", {16'd0, frames_out}, 32'd4);

    // 4: a 15-cycle gap is just inside the timeout window.
    t0 = to_cnt;
    base = out_q.size();
    send(32'h51);
    send(32'h52);
    repeat (15) tick();
    send(32'h53);
    send(32'h54);
    wait_log(base + 4, 50);
    check("t4_no_timeout", to_cnt - t0, 32'd0);
    check_frame("t4", base, 32'h51, 32'h52, 32'h53, 32'h54);
    check("t4_frames", {16'd0, frames_out}, 32'd5);

    // 5: random backpressure; presented data must not move while stalled.
    consumed_in = 1'b0;
    base = out_q.size();
    for (int i = 0; i < 4; i++) send(32'hE0 + i);
    prev_v = 1'b0;
    prev_c = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (prev_v && !prev_c) begin
        check("t5_hold_valid", {31'd0, valid_out}, 32'd1);
        check("t5_hold_data", data_out, prev_data);
      end
      prev_v = valid_out;
      prev_data = data_out;
      consumed_in = 1'($urandom_range(0, 1));
      prev_c = consumed_in;
    end
    consumed_in = 1'b1;
    wait_log(base + 4, 50);
    check_frame("t5", base, 32'hE0, 32'hE1, 32'hE2, 32'hE3);

    // 6: reset mid-stream with a partial frame pending.
    consumed_in = 1'b0;
    for (int i = 0; i < 4; i++) send(32'hF0 + i);
    send(32'h61);
    send(32'h62);
    tick();
    check("t6_streaming", {31'd0, valid_out}, 32'd1);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check_idle_outputs("t6_reset");
    consumed_in = 1'b1;
    base = out_q.size();
    for (int i = 0; i < 4; i++) send(32'h71 + i);
    wait_log(base + 4, 50);
    check_frame("t6", base, 32'h71, 32'h72, 32'h73, 32'h74);
    check("t6_frames", {16'd0, frames_out}, 32'd1);
    check("t6_log_exact", out_q.size(), base + 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
